// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
//   wb_sel_e    : result select carried with each instruction
//   F3_*        : load funct3 encodings (width and signedness)
//   wb_state_e  : writeback controller states
package wb_pkg;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_PC4  = 2'd2,
        WB_LOAD = 2'd3
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        WB_IDLE      = 1'b0,
        WB_WAIT_LOAD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/writeback_unit_load_align_ext.sv
// Combinational load data extraction and misalignment check.
// Ports:
//   funct3     in  load width/sign encoding
//   offset     in  byte offset of the effective address within the word
//   word       in  aligned memory word holding the load data
//   data       out extracted and sign/zero-extended load value
//   misaligned out access does not fit its natural alignment, or funct3
//                  is not a legal load encoding
module load_align_ext
    import wb_pkg::*;
#(
    parameter int WORD_LEN = 32
) (
    input  logic [2:0]          funct3,
    input  logic [1:0]          offset,
    input  logic [WORD_LEN-1:0] word,
    output logic [WORD_LEN-1:0] data,
    output logic                misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{offset, 3'b000} +: 8];
    assign half_sel = word[{offset[1], 4'b0000} +: 16];

    always_comb begin
        data       = word;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  data = {{(WORD_LEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU: data = {{(WORD_LEN-8){1'b0}}, byte_sel};
            F3_LH: begin
                data       = {{(WORD_LEN-16){half_sel[15]}}, half_sel};
                misaligned = offset[0];
            end
            F3_LHU: begin
                data       = {{(WORD_LEN-16){1'b0}}, half_sel};
                misaligned = offset[0];
            end
            F3_LW: begin
                data       = word;
                misaligned = (offset != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage feeding the register file write port.
// Accepts retired instructions over valid/ready, selects ALU / PC+4 / load
// data, waits for load responses, and issues one registered register-file
// write plus a commit pulse per instruction.
// Ports:
//   clk, reset                      clock, synchronous active-low reset
//   in_valid/in_ready               instruction handshake (ready only in IDLE)
//   in_pc, in_rd, in_wb_sel         instruction PC, destination, result select
//   in_alu_result, in_funct3        ALU result / load address, load type
//   mem_rvalid, mem_rdata           load response
//   rf_waddr, rf_wdata, rf_wen      register file write (registered)
//   commit_valid, commit_pc         retirement pulse and PC (registered)
//   load_misaligned                 pulse on a rejected misaligned load
//
// state        | meaning
// -------------+-------------------------------------------------------
// WB_IDLE      | ready; non-loads and misaligned loads retire next cycle
// WB_WAIT_LOAD | load accepted, waiting for mem_rvalid (no timeout)
module writeback_unit
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int WORD_LEN   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_LEN-1:0]   in_pc,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic [1:0]            in_wb_sel,
    input  logic [WORD_LEN-1:0]   in_alu_result,
    input  logic [2:0]            in_funct3,
    input  logic                  mem_rvalid,
    input  logic [WORD_LEN-1:0]   mem_rdata,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [WORD_LEN-1:0]   rf_wdata,
    output logic                  rf_wen,
    output logic                  commit_valid,
    output logic [WORD_LEN-1:0]   commit_pc,
    output logic                  load_misaligned
);

    wb_state_e state_q, state_d;
    wb_sel_e   sel;
    logic      accept;

    logic [2:0]            ld_f3_q;
    logic [1:0]            ld_off_q;
    logic [ADDR_WIDTH-1:0] ld_rd_q;
    logic [WORD_LEN-1:0]   ld_pc_q;

    logic [2:0]          al_f3;
    logic [1:0]          al_off;
    logic [WORD_LEN-1:0] al_data;
    logic                al_mis;

    logic                  wen_d, commit_d, mis_d;
    logic [ADDR_WIDTH-1:0] waddr_d;
    logic [WORD_LEN-1:0]   wdata_d, pc_d;

    assign sel      = wb_sel_e'(in_wb_sel);
    assign in_ready = (state_q == WB_IDLE);
    assign accept   = in_valid && in_ready;

    // One aligner serves both uses: in IDLE it checks alignment of the
    // incoming load, in WAIT_LOAD it extracts data with the latched type.
    assign al_f3  = (state_q == WB_IDLE) ? in_funct3 : ld_f3_q;
    assign al_off = (state_q == WB_IDLE) ? in_alu_result[1:0] : ld_off_q;

    load_align_ext #(.WORD_LEN(WORD_LEN)) u_align (
        .funct3     (al_f3),
        .offset     (al_off),
        .word       (mem_rdata),
        .data       (al_data),
        .misaligned (al_mis)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= WB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_IDLE:
                if (accept && sel == WB_LOAD && !al_mis) state_d = WB_WAIT_LOAD;
            WB_WAIT_LOAD:
                if (mem_rvalid) state_d = WB_IDLE;
            default: state_d = WB_IDLE;
        endcase
    end

    always_comb begin
        wen_d    = 1'b0;
        commit_d = 1'b0;
        mis_d    = 1'b0;
        waddr_d  = rf_waddr;
        wdata_d  = rf_wdata;
        pc_d     = commit_pc;
        case (state_q)
            WB_IDLE: begin
                if (accept) begin
                    if (sel == WB_LOAD) begin
                        if (al_mis) begin
                            commit_d = 1'b1;
                            mis_d    = 1'b1;
                            pc_d     = in_pc;
                        end
                    end else begin
                        commit_d = 1'b1;
                        pc_d     = in_pc;
                        waddr_d  = in_rd;
                        wdata_d  = (sel == WB_PC4) ? in_pc + WORD_LEN'(4) : in_alu_result;
                        wen_d    = (sel != WB_NONE) && (in_rd != '0);
                    end
                end
            end
            WB_WAIT_LOAD: begin
                if (mem_rvalid) begin
                    commit_d = 1'b1;
                    pc_d     = ld_pc_q;
                    waddr_d  = ld_rd_q;
                    wdata_d  = al_data;
                    wen_d    = (ld_rd_q != '0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_wen          <= 1'b0;
            rf_waddr        <= '0;
            rf_wdata        <= '0;
            commit_valid    <= 1'b0;
            commit_pc       <= '0;
            load_misaligned <= 1'b0;
        end else begin
            rf_wen          <= wen_d;
            rf_waddr        <= waddr_d;
            rf_wdata        <= wdata_d;
            commit_valid    <= commit_d;
            commit_pc       <= pc_d;
            load_misaligned <= mis_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ld_f3_q  <= '0;
            ld_off_q <= '0;
            ld_rd_q  <= '0;
            ld_pc_q  <= '0;
        end else if (accept && sel == WB_LOAD) begin
            ld_f3_q  <= in_funct3;
            ld_off_q <= in_alu_result[1:0];
            ld_rd_q  <= in_rd;
            ld_pc_q  <= in_pc;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_result;
    logic [2:0]  in_funct3;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_wen;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        load_misaligned;

    writeback_unit #(.ADDR_WIDTH(5), .WORD_LEN(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_pc           (in_pc),
        .in_rd           (in_rd),
        .in_wb_sel       (in_wb_sel),
        .in_alu_result   (in_alu_result),
        .in_funct3       (in_funct3),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata),
        .rf_wen          (rf_wen),
        .commit_valid    (commit_valid),
        .commit_pc       (commit_pc),
        .load_misaligned (load_misaligned)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state: one outstanding load at most.
    bit          m_busy = 0;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [31:0] m_addr;
    logic [31:0] m_pc;

    logic [4:0]  e_waddr = 0;
    logic [31:0] e_wdata = 0;
    logic        e_wen = 0;
    logic        e_commit = 0;
    logic [31:0] e_pc = 0;
    logic        e_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned size;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    return 1;
        endcase
        return (addr % size) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] w);
        int unsigned off;
        logic [31:0] b, h;
        off = addr % 4;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0: return (b >= 32'h80) ? b - 32'h100 : b;
            3'd4: return b;
            3'd1: return (h >= 32'h8000) ? h - 32'h10000 : h;
            3'd5: return h;
            default: return w;
        endcase
    endfunction

    // Drives one cycle of inputs at the negedge, advances the model, and
    // compares every output at the following negedge.
    task automatic step(input logic rst, input logic v, input logic [1:0] sel,
                        input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] alu,
                        input logic [2:0] f3, input logic rv, input logic [31:0] rdata);
        reset = rst; in_valid = v; in_wb_sel = sel; in_rd = rd; in_pc = pc;
        in_alu_result = alu; in_funct3 = f3; mem_rvalid = rv; mem_rdata = rdata;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
        e_wen = 0; e_commit = 0; e_mis = 0;
        if (!rst) begin
            m_busy = 0;
            e_waddr = 0; e_wdata = 0; e_pc = 0;
        end else if (!m_busy) begin
            if (v) begin
                if (sel == 2'd3) begin
                    if (m_misaligned(f3, alu)) begin
                        e_commit = 1; e_mis = 1; e_pc = pc;
                    end else begin
                        m_busy = 1; m_rd = rd; m_f3 = f3; m_addr = alu; m_pc = pc;
                    end
                end else begin
                    e_commit = 1; e_pc = pc; e_waddr = rd;
                    e_wdata = (sel == 2'd2) ? pc + 32'd4 : alu;
                    e_wen = (sel != 2'd0) && (rd != 0);
                end
            end
        end else if (rv) begin
            e_commit = 1; e_pc = m_pc; e_waddr = m_rd;
            e_wdata = m_load(m_f3, m_addr, rdata);
            e_wen = (m_rd != 0);
            m_busy = 0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("rf_wen", {31'd0, rf_wen}, {31'd0, e_wen});
        chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, e_waddr});
        chk("rf_wdata", rf_wdata, e_wdata);
        chk("commit_valid", {31'd0, commit_valid}, {31'd0, e_commit});
        chk("commit_pc", commit_pc, e_pc);
        chk("load_misaligned", {31'd0, load_misaligned}, {31'd0, e_mis});
    endtask

    task automatic idle(input logic rv, input logic [31:0] rdata);
        // in_valid held high with junk to show it is ignored while busy
        step(1, 1, 2'd1, 5'd9, 32'hDEAD0000, 32'h5555AAAA, 3'd0, rv, rdata);
    endtask

    initial begin
        reset = 0; in_valid = 0; in_wb_sel = 0; in_rd = 0; in_pc = 0;
        in_alu_result = 0; in_funct3 = 0; mem_rvalid = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);

        // Reset state
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_reset_ready", {31'd0, in_ready}, 32'd1);
        chk("lit_reset_commit", {31'd0, commit_valid}, 32'd0);
        chk("lit_reset_wdata", rf_wdata, 32'd0);

        // Back-to-back ALU writes
        step(1, 1, 2'd1, 5'd5, 32'h100, 32'h1234, 0, 0, 0);
        chk("lit_alu0_wdata", rf_wdata, 32'h1234);
        chk("lit_alu0_waddr", {27'd0, rf_waddr}, 32'd5);
        step(1, 1, 2'd1, 5'd6, 32'h104, 32'hFFFFFFFF, 0, 0, 0);
        chk("lit_alu1_wdata", rf_wdata, 32'hFFFFFFFF);
        chk("lit_alu1_pc", commit_pc, 32'h104);

        // PC+4 wraparound
        step(1, 1, 2'd2, 5'd1, 32'hFFFFFFFC, 32'h0, 0, 0, 0);
        chk("lit_pc4_wdata", rf_wdata, 32'h0);
        chk("lit_pc4_wen", {31'd0, rf_wen}, 32'd1);

        // LB at offset 3, rvalid in accept cycle is ignored, response 3 cycles later
        step(1, 1, 2'd3, 5'd7, 32'h200, 32'h1003, 3'd0, 1, 32'h12345678);
        chk("lit_lb_ready_low", {31'd0, in_ready}, 32'd0);
        idle(0, 0);
        idle(0, 0);
        idle(1, 32'h80FF0000);
        chk("lit_lb_wdata", rf_wdata, 32'hFFFFFF80);
        chk("lit_lb_ready_back", {31'd0, in_ready}, 32'd1);

        // LBU on the same data
        step(1, 1, 2'd3, 5'd8, 32'h204, 32'h1003, 3'd4, 0, 0);
        idle(1, 32'h80FF0000);
        chk("lit_lbu_wdata", rf_wdata, 32'h00000080);

        // LH offset 2
        step(1, 1, 2'd3, 5'd10, 32'h208, 32'h2002, 3'd1, 0, 0);
        idle(0, 0);
        idle(1, 32'h80011234);
        chk("lit_lh_wdata", rf_wdata, 32'hFFFF8001);

        // LHU offset 1: misaligned, stays IDLE
        step(1, 1, 2'd3, 5'd11, 32'h20C, 32'h2001, 3'd5, 0, 0);
        chk("lit_mis_flag", {31'd0, load_misaligned}, 32'd1);
        chk("lit_mis_wen", {31'd0, rf_wen}, 32'd0);
        chk("lit_mis_ready", {31'd0, in_ready}, 32'd1);

        // rd == 0 for ALU and LOAD
        step(1, 1, 2'd1, 5'd0, 32'h300, 32'hABCD, 0, 0, 0);
        chk("lit_rd0_alu_wen", {31'd0, rf_wen}, 32'd0);
        step(1, 1, 2'd3, 5'd0, 32'h304, 32'h4000, 3'd2, 0, 0);
        idle(1, 32'hCAFEF00D);
        chk("lit_rd0_ld_commit", {31'd0, commit_valid}, 32'd1);
        chk("lit_rd0_ld_wen", {31'd0, rf_wen}, 32'd0);

        // Reset during WAIT_LOAD drops the load
        step(1, 1, 2'd3, 5'd12, 32'h400, 32'h5000, 3'd2, 0, 0);
        idle(0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_rst_wait_ready", {31'd0, in_ready}, 32'd1);
        step(1, 0, 0, 0, 0, 0, 0, 1, 32'h11111111);
        chk("lit_rst_wait_wen", {31'd0, rf_wen}, 32'd0);
        chk("lit_rst_wait_commit", {31'd0, commit_valid}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic r;
            logic [31:0] addr;
            r = ($urandom_range(0, 99) != 0);
            addr = $urandom;
            step(r, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 5'($urandom_range(0, 31)), $urandom, addr,
                 3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
